// File: rtl/regbank_display_scan.sv
// Scans NDIG consecutive register-bank entries onto a common-anode 7-segment display,
// one digit at a time, with an all-off blanking gap before each digit.
module regbank_display_scan #(
    parameter int unsigned BIT_ADDR = 4,
    parameter int unsigned BIT_DATO = 4,
    parameter int unsigned NDIG     = 4,
    parameter int unsigned DIV      = 50000,
    parameter int unsigned BLANK    = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   en,
    input  logic [BIT_ADDR-1:0]                    base_addr,
    output logic [BIT_ADDR-1:0]                    addr_rd,
    input  logic [BIT_DATO-1:0]                    dat_rd,
    output logic [6:0]                             seg,
    output logic [NDIG-1:0]                        an,
    output logic [((NDIG > 1) ? $clog2(NDIG) : 1)-1:0] dig_idx,
    output logic                                   frame_tick
);

    localparam int unsigned IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int unsigned CMAX = (DIV > BLANK) ? DIV : BLANK;
    localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_LATCH = 2'd2,
        S_SHOW  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [3:0]         latch_q, latch_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [BIT_ADDR-1:0] addr_q, addr_d;
    logic [NDIG-1:0]    an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               tick_q, tick_d;
    logic [3:0]         dat_nib_c;
    logic               show_exit_c;
    logic               blank_entry_c;

    // Only the low nibble is displayed; narrow banks are zero-extended.
    generate
        if (BIT_DATO >= 4) begin : g_nib_wide
            assign dat_nib_c = dat_rd[3:0];
        end else begin : g_nib_narrow
            assign dat_nib_c = 4'(dat_rd);
        end
    endgenerate

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Dwell counter restarts on every state change; en low always wins.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!en) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                end
                S_BLANK: begin
                    if (cnt_q == CW'(BLANK - 1)) begin
                        state_d = S_LATCH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_LATCH: begin
                    state_d = S_SHOW;
                    cnt_d   = '0;
                end
                S_SHOW: begin
                    if (cnt_q == CW'(DIV - 1)) begin
                        state_d = S_BLANK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        show_exit_c   = en && (state_q == S_SHOW) && (cnt_q == CW'(DIV - 1));
        blank_entry_c = (state_d == S_BLANK) && (state_q != S_BLANK);

        idx_d = idx_q;
        if (state_d == S_IDLE) begin
            idx_d = '0;
        end else if (show_exit_c) begin
            idx_d = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + IW'(1);
        end

        addr_d = addr_q;
        if (blank_entry_c) begin
            addr_d = base_addr + BIT_ADDR'(idx_d);
        end

        // Capture on the BLANK->LATCH edge so data is stable for all of SHOW.
        latch_d = latch_q;
        if ((state_q == S_BLANK) && (state_d == S_LATCH)) begin
            latch_d = dat_nib_c;
        end

        an_d  = '1;
        seg_d = 7'h7F;
        if (state_d == S_SHOW) begin
            an_d  = ~(NDIG'(1) << idx_d);
            seg_d = hex7(latch_q);
        end

        tick_d = show_exit_c && (idx_q == IW'(NDIG - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            latch_q <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            an_q    <= '1;
            seg_q   <= 7'h7F;
            tick_q  <= 1'b0;
        end else begin
            latch_q <= latch_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            tick_q  <= tick_d;
        end
    end

    assign addr_rd    = addr_q;
    assign an         = an_q;
    assign seg        = seg_q;
    assign dig_idx    = idx_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_regbank_display_scan.sv
// Bench for regbank_display_scan: timeline model of the scan plus directed literal checks.
module tb_regbank_display_scan;

    localparam int NDIG_C  = 4;
    localparam int DIV_C   = 4;
    localparam int BLANK_C = 2;
    localparam int P       = BLANK_C + 1 + DIV_C;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] base_addr;
    logic [3:0] addr_rd;
    logic [3:0] dat_rd;
    logic [6:0] seg;
    logic [3:0] an;
    logic [1:0] dig_idx;
    logic       frame_tick;

    logic [3:0] breg [16];
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    assign dat_rd = breg[addr_rd];

    always #5 clk = ~clk;

    regbank_display_scan #(
        .BIT_ADDR(4), .BIT_DATO(4), .NDIG(NDIG_C), .DIV(DIV_C), .BLANK(BLANK_C)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .base_addr(base_addr), .addr_rd(addr_rd),
        .dat_rd(dat_rd), .seg(seg), .an(an), .dig_idx(dig_idx), .frame_tick(frame_tick)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: t counts edges since scan start; digit and phase follow from t alone.
    bit         running;
    int         t, digit, ph;
    logic [3:0] m_latch;
    logic [3:0] one4 = 4'b0001;
    logic [3:0] exp_an, exp_addr;
    logic [6:0] exp_seg;
    logic [1:0] exp_idx;
    logic       exp_tick;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            running = 1'b0; t = 0; m_latch = '0;
            exp_an = 4'hF; exp_seg = 7'h7F; exp_addr = '0; exp_idx = '0; exp_tick = 1'b0;
        end else if (!en) begin
            running = 1'b0; t = 0;
            exp_an = 4'hF; exp_seg = 7'h7F; exp_idx = '0; exp_tick = 1'b0;
        end else begin
            if (running) t++;
            else begin
                running = 1'b1;
                t = 0;
            end
            digit    = (t / P) % NDIG_C;
            ph       = t % P;
            exp_idx  = 2'(digit);
            exp_tick = (ph == 0) && (digit == 0) && (t > 0);
            if (ph == 0) exp_addr = 4'((int'(base_addr) + digit) % 16);
            if (ph == BLANK_C) m_latch = breg[exp_addr];
            if (ph > BLANK_C) begin
                exp_an  = ~(one4 << digit);
                exp_seg = seg_tab[m_latch];
            end else begin
                exp_an  = 4'hF;
                exp_seg = 7'h7F;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (check_en) begin
            chk("m_an", 32'(an), 32'(exp_an));
            chk("m_seg", 32'(seg), 32'(exp_seg));
            chk("m_addr", 32'(addr_rd), 32'(exp_addr));
            chk("m_idx", 32'(dig_idx), 32'(exp_idx));
            chk("m_tick", 32'(frame_tick), 32'(exp_tick));
        end
    end

    // Restart the scan from IDLE; the next rising edge enters BLANK of digit 0.
    task automatic start_scan(input logic [3:0] b);
        @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
        base_addr = b;
        en = 1'b1;
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    int ticks;

    initial begin
        rst = 1'b0; en = 1'b0; base_addr = '0;
        for (int k = 0; k < 16; k++) breg[k] = 4'(k);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check_en = 1'b1;
        adv(3);
        chk("idle_an", 32'(an), 32'hF);
        chk("idle_seg", 32'(seg), 32'h7F);

        // Scan order and frame tick
        start_scan(4'h0);
        adv(4);
        chk("d0_an", 32'(an), 32'b1110); chk("d0_seg", 32'(seg), 32'b1000000); chk("d0_addr", 32'(addr_rd), 32'h0);
        adv(7);
        chk("d1_an", 32'(an), 32'b1101); chk("d1_seg", 32'(seg), 32'b1111001); chk("d1_addr", 32'(addr_rd), 32'h1);
        adv(7);
        chk("d2_an", 32'(an), 32'b1011); chk("d2_seg", 32'(seg), 32'b0100100); chk("d2_addr", 32'(addr_rd), 32'h2);
        adv(7);
        chk("d3_an", 32'(an), 32'b0111); chk("d3_seg", 32'(seg), 32'b0110000); chk("d3_idx", 32'(dig_idx), 32'd3);
        adv(4);
        chk("tick_hi", 32'(frame_tick), 32'd1); chk("tick_addr", 32'(addr_rd), 32'h0);
        chk("tick_idx", 32'(dig_idx), 32'd0);
        ticks = 0;
        for (int i = 0; i < 56; i++) begin
            adv(1);
            ticks += int'(frame_tick);
        end
        chk("tick_count", 32'(ticks), 32'd2);

        // Address wrap
        start_scan(4'hE);
        adv(4);
        chk("w0_seg", 32'(seg), 32'b0000110); chk("w0_addr", 32'(addr_rd), 32'hE);
        adv(7);
        chk("w1_seg", 32'(seg), 32'b0001110); chk("w1_addr", 32'(addr_rd), 32'hF);
        adv(7);
        chk("w2_seg", 32'(seg), 32'b1000000); chk("w2_addr", 32'(addr_rd), 32'h0);
        adv(7);
        chk("w3_seg", 32'(seg), 32'b1111001); chk("w3_addr", 32'(addr_rd), 32'h1);

        // Bank update during SHOW appears only on the next visit
        start_scan(4'h0);
        adv(18);
        chk("u_an", 32'(an), 32'b1011); chk("u_seg_old", 32'(seg), 32'b0100100);
        @(negedge clk);
        breg[2] = 4'h8;
        adv(1);
        chk("u_seg_hold", 32'(seg), 32'b0100100);
        adv(27);
        chk("u_an_next", 32'(an), 32'b1011); chk("u_seg_new", 32'(seg), 32'b0000000);
        @(negedge clk);
        breg[2] = 4'h2;

        // Enable drop mid-SHOW of digit 1
        start_scan(4'h0);
        adv(11);
        chk("e_an_d1", 32'(an), 32'b1101);
        @(negedge clk);
        en = 1'b0;
        adv(1);
        chk("e_off_an", 32'(an), 32'hF); chk("e_off_idx", 32'(dig_idx), 32'd0);
        chk("e_off_seg", 32'(seg), 32'h7F);
        @(negedge clk);
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            adv(1);
            chk("e_blank_an", 32'(an), 32'hF);
        end
        adv(1);
        chk("e_resume_an", 32'(an), 32'b1110); chk("e_resume_seg", 32'(seg), 32'b1000000);

        // Asynchronous reset mid-SHOW
        start_scan(4'h9);
        adv(5);
        chk("r_pre_an", 32'(an), 32'b1110); chk("r_pre_seg", 32'(seg), 32'b0010000);
        chk("r_pre_addr", 32'(addr_rd), 32'h9);
        #1 rst = 1'b0;
        #1;
        chk("r_an", 32'(an), 32'hF); chk("r_seg", 32'(seg), 32'h7F);
        chk("r_addr", 32'(addr_rd), 32'h0); chk("r_idx", 32'(dig_idx), 32'd0);
        chk("r_tick", 32'(frame_tick), 32'd0);
        @(negedge clk);
        en = 1'b0;
        rst = 1'b1;
        adv(10);
        chk("r_idle_an", 32'(an), 32'hF); chk("r_idle_seg", 32'(seg), 32'h7F);

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
